// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and helpers for the shared add/sub arbiter.
//   OPW       operand / result width
//   state_e   result-slot state (empty / full)
//   calc_ovf  overflow / borrow flag from the adder carries
package adder_arb_pkg;

   localparam int unsigned OPW = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Signed: carry into MSB differs from carry out. Unsigned sub: no carry out means borrow.
   function automatic logic calc_ovf(input logic sub, input logic sign, input logic c15,
                                     input logic c16);
      if (sign) begin
         return c15 ^ c16;
      end
      return sub ? ~c16 : c16;
   endfunction

endpackage

// File: rtl/cla_addsub16.sv
// cla_addsub16: 16-bit carry-lookahead adder/subtractor.
//   a_i, b_i  operands
//   sub_i     1 = a - b, 0 = a + b
//   sum_o     result mod 2^16
//   c15_o     carry into bit 15
//   c16_o     carry out of bit 15
module cla_addsub16
   import adder_arb_pkg::*;
(
   input  logic [OPW-1:0] a_i,
   input  logic [OPW-1:0] b_i,
   input  logic           sub_i,
   output logic [OPW-1:0] sum_o,
   output logic           c15_o,
   output logic           c16_o
);

   localparam int unsigned NIB = OPW / 4;

   logic [OPW-1:0] b_x, g, p;
   logic [OPW:0]   c;
   logic [NIB-1:0] gg, gp;
   logic [NIB:0]   gc;

   assign b_x = b_i ^ {OPW{sub_i}};
   assign g   = a_i & b_x;
   assign p   = a_i ^ b_x;

   always_comb begin
      gg = '0;
      gp = '0;
      gc = '0;
      c  = '0;
      // Nibble-level generate/propagate, then lookahead across nibbles.
      for (int j = 0; j < NIB; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      gc[0] = sub_i;
      for (int j = 0; j < NIB; j++) begin
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
      for (int j = 0; j < NIB; j++) begin
         c[4*j] = gc[j];
         for (int k = 0; k < 3; k++) begin
            c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
         end
      end
      c[OPW] = gc[NIB];
   end

   assign sum_o = p ^ c[OPW-1:0];
   assign c15_o = c[OPW-1];
   assign c16_o = c[OPW];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i      request vector
//   ptr_i      highest-priority index
//   en_i       when low, no grant is issued
//   gnt_o      one-hot grant
//   gnt_idx_o  index of the granted request (0 when none)
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [ID_W-1:0] ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [ID_W-1:0] gnt_idx_o
);

   always_comb begin
      int unsigned idx;
      logic        found;
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      // Scan in circular order starting at ptr_i; the first hit wins.
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr_i) + k) % NREQ;
         if (en_i && !found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one CLA add/sub unit shared round-robin by NREQ requesters,
// with a single registered result slot.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   per-requester handshake (ready is the one-hot grant)
//   req_a_i, req_b_i      packed operands, requester i at [16*i +: 16]
//   req_sub_i, req_sign_i per-requester op select and overflow rule
//   resp_valid_o/ready_i  result handshake
//   resp_id_o/sum_o/ovf_o result fields
// Optional: define ADDER_ARB_PERF_EN to add perf_ops_o / perf_stall_o counters.
module adder_share_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = $clog2(NREQ)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NREQ-1:0]     req_valid_i,
   output logic [NREQ-1:0]     req_ready_o,
   input  logic [NREQ*OPW-1:0] req_a_i,
   input  logic [NREQ*OPW-1:0] req_b_i,
   input  logic [NREQ-1:0]     req_sub_i,
   input  logic [NREQ-1:0]     req_sign_i,
   output logic                resp_valid_o,
   input  logic                resp_ready_i,
   output logic [ID_W-1:0]     resp_id_o,
   output logic [OPW-1:0]      resp_sum_o,
   output logic                resp_ovf_o
`ifdef ADDER_ARB_PERF_EN
   ,
   output logic [31:0]         perf_ops_o,
   output logic [31:0]         perf_stall_o
`endif
);

   state_e          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] id_q;
   logic [OPW-1:0]  sum_q;
   logic            ovf_q;

   logic            can_accept, grant;
   logic [NREQ-1:0] gnt;
   logic [ID_W-1:0] gnt_idx;
   logic [OPW-1:0]  a_sel, b_sel, sum;
   logic            sub_sel, sign_sel, c15, c16;

   // Slot can take a new op if empty or being drained this cycle; never grant in reset.
   assign can_accept = (state_q == ST_EMPTY) | resp_ready_i;

   rr_arbiter #(
      .NREQ(NREQ),
      .ID_W(ID_W)
   ) u_arb (
      .req_i    (req_valid_i),
      .ptr_i    (rr_ptr_q),
      .en_i     (can_accept & ~rst_i),
      .gnt_o    (gnt),
      .gnt_idx_o(gnt_idx)
   );

   assign grant    = |gnt;
   assign a_sel    = req_a_i[OPW*gnt_idx +: OPW];
   assign b_sel    = req_b_i[OPW*gnt_idx +: OPW];
   assign sub_sel  = req_sub_i[gnt_idx];
   assign sign_sel = req_sign_i[gnt_idx];

   cla_addsub16 u_cla (
      .a_i  (a_sel),
      .b_i  (b_sel),
      .sub_i(sub_sel),
      .sum_o(sum),
      .c15_o(c15),
      .c16_o(c16)
   );

   // FSM: state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: if (grant) state_d = ST_FULL;
         ST_FULL:  if (resp_ready_i && !grant) state_d = ST_EMPTY;
      endcase
   end

   // FSM: outputs
   always_comb begin
      resp_valid_o = (state_q == ST_FULL);
      req_ready_o  = gnt;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         id_q     <= '0;
         sum_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (grant) begin
            id_q  <= gnt_idx;
            sum_q <= sum;
            ovf_q <= calc_ovf(sub_sel, sign_sel, c15, c16);
         end
      end
   end

   assign resp_id_o  = id_q;
   assign resp_sum_o = sum_q;
   assign resp_ovf_o = ovf_q;

`ifdef ADDER_ARB_PERF_EN
   logic [31:0] perf_ops_q, perf_stall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (resp_valid_o && resp_ready_i) perf_ops_q <= perf_ops_q + 32'd1;
         if (|req_valid_i && !grant)        perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_ops_o   = perf_ops_q;
   assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: scoreboard bench for adder_share_arbiter (NREQ = 4).
module tb_adder_share_arbiter;

   localparam int unsigned NREQ = 4;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] sum;
      logic        ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_ready;
   logic [NREQ*16-1:0] req_a, req_b;
   logic [NREQ-1:0]  req_sub, req_sign;
   logic             resp_valid, resp_ready;
   logic [1:0]       resp_id;
   logic [15:0]      resp_sum;
   logic             resp_ovf;
`ifdef ADDER_ARB_PERF_EN
   logic [31:0]      perf_ops, perf_stall;
`endif

   exp_t sb[$];
   int   m_ptr;
   int   n_vec = 0;
   int   n_err = 0;
   bit   drop_mode = 1'b0;

   always #5 clk = ~clk;

   adder_share_arbiter #(
      .NREQ(NREQ)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .req_sub_i   (req_sub),
      .req_sign_i  (req_sign),
      .resp_valid_o(resp_valid),
      .resp_ready_i(resp_ready),
      .resp_id_o   (resp_id),
      .resp_sum_o  (resp_sum),
      .resp_ovf_o  (resp_ovf)
`ifdef ADDER_ARB_PERF_EN
      ,
      .perf_ops_o  (perf_ops),
      .perf_stall_o(perf_stall)
`endif
   );

   function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic sign);
      exp_t        e;
      logic [16:0] full;
      full  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      e.id  = 2'(id);
      e.sum = full[15:0];
      if (sign) begin
         e.ovf = sub ? ((a[15] != b[15]) && (e.sum[15] != a[15]))
                     : ((a[15] == b[15]) && (e.sum[15] != a[15]));
      end else begin
         e.ovf = sub ? (a < b) : full[16];
      end
      return e;
   endfunction

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic sign);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_sub[i]        = sub;
      req_sign[i]       = sign;
      req_valid[i]      = 1'b1;
   endtask

   // Called at a negedge with inputs already driven; checks this cycle and returns at next negedge.
   task automatic cycle();
      logic [NREQ-1:0] exp_gnt;
      int              g;
      bit              can;
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         if (resp_valid !== 1'b1 || resp_id !== sb[0].id || resp_sum !== sb[0].sum ||
             resp_ovf !== sb[0].ovf) begin
            n_err++;
            $display("FAIL resp: got v=%b id=%0d sum=%h ovf=%b, want v=1 id=%0d sum=%h ovf=%b",
                     resp_valid, resp_id, resp_sum, resp_ovf, sb[0].id, sb[0].sum, sb[0].ovf);
         end
      end else if (resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL resp_valid: got %b, want 0", resp_valid);
      end
      can     = (sb.size() == 0) || resp_ready;
      g       = -1;
      exp_gnt = '0;
      if (can) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_gnt[g] = 1'b1;
      n_vec++;
      if (req_ready !== exp_gnt) begin
         n_err++;
         $display("FAIL req_ready: got %b, want %b", req_ready, exp_gnt);
      end
      if (sb.size() != 0 && resp_ready) void'(sb.pop_front());
      if (g >= 0) begin
         sb.push_back(model(g, req_a[16*g +: 16], req_b[16*g +: 16], req_sub[g], req_sign[g]));
         m_ptr = (g + 1) % NREQ;
      end
      @(negedge clk);
      if (drop_mode && g >= 0) req_valid[g] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      req_valid  = '0;
      resp_ready = 1'b1;
      while (sb.size() != 0 && n < 10) begin
         cycle();
         n++;
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results still pending, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_ptr = 0;
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if ({resp_valid, resp_id, resp_sum, resp_ovf} !== '0) begin
         n_err++;
         $display("FAIL por_resp: got v=%b id=%0d sum=%h ovf=%b, want all 0",
                  resp_valid, resp_id, resp_sum, resp_ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_ptr      = 0;
      resp_ready = 1'b0;
      set_req(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
      cycle();
      cycle();
      for (int i = 1; i < NREQ; i++) set_req(i, 16'(i * 3), 16'(i), 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({resp_valid, resp_id, resp_sum, resp_ovf} !== '0) begin
         n_err++;
         $display("FAIL async_reset_resp: got v=%b id=%0d sum=%h ovf=%b, want all 0",
                  resp_valid, resp_id, resp_sum, resp_ovf);
      end
      n_vec++;
      if (req_ready !== '0) begin
         n_err++;
         $display("FAIL reset_req_ready: got %b, want 0000", req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_ptr      = 0;
      resp_ready = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL first_after_reset: got %b, want 0001", req_ready);
      end
      cycle();
      drain();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h1000 * (i + 1) + i), 16'(i + 5), 1'(i), 1'b0);
      resp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         #1;
         n_vec++;
         if (resp_id !== 2'(k % NREQ)) begin
            n_err++;
            $display("FAIL rr_id[%0d]: got %0d, want %0d", k, resp_id, k % NREQ);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'hA000 + i), 16'(16'h0F00 >> i), 1'b1, 1'b1);
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      repeat (3) cycle();
      resp_ready = 1'b1;
      #1;
      n_vec++;
      if (req_ready === '0) begin
         n_err++;
         $display("FAIL release_grant: got %b, want a grant", req_ready);
      end
      cycle();
      drain();
   endtask

   task automatic test_signed_ovf();
      resp_ready = 1'b1;
      set_req(1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
      cycle();
      req_valid = '0;
      #1;
      n_vec++;
      if (resp_sum !== 16'h8000 || resp_ovf !== 1'b1) begin
         n_err++;
         $display("FAIL signed_ovf: got sum=%h ovf=%b, want sum=8000 ovf=1", resp_sum, resp_ovf);
      end
      cycle();
      set_req(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      cycle();
      req_valid = '0;
      #1;
      n_vec++;
      if (resp_sum !== 16'h8000 || resp_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL unsigned_no_ovf: got sum=%h ovf=%b, want sum=8000 ovf=0", resp_sum, resp_ovf);
      end
      cycle();
      drain();
   endtask

   task automatic test_unsigned_borrow();
      resp_ready = 1'b1;
      set_req(2, 16'h0003, 16'h0005, 1'b1, 1'b0);
      cycle();
      req_valid = '0;
      #1;
      n_vec++;
      if (resp_sum !== 16'hFFFE || resp_ovf !== 1'b1) begin
         n_err++;
         $display("FAIL borrow: got sum=%h ovf=%b, want sum=fffe ovf=1", resp_sum, resp_ovf);
      end
      cycle();
      set_req(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      cycle();
      req_valid = '0;
      #1;
      n_vec++;
      if (resp_sum !== 16'h0000 || resp_ovf !== 1'b1) begin
         n_err++;
         $display("FAIL carry_out: got sum=%h ovf=%b, want sum=0000 ovf=1", resp_sum, resp_ovf);
      end
      cycle();
      drain();
   endtask

   task automatic test_random();
      drop_mode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
               set_req(i, 16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)),
                       1'($urandom_range(1, 0)));
            end
         end
         resp_ready = ($urandom_range(3, 0) != 0);
         cycle();
      end
      drop_mode = 1'b0;
      drain();
   endtask

`ifdef ADDER_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      resp_ready = 1'b1;
      set_req(0, 16'h0101, 16'h0202, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 5) begin
            resp_ready = 1'b0;
            repeat (4) cycle();
            resp_ready = 1'b1;
         end
         cycle();
      end
      req_valid = '0;
      cycle();
      #1;
      n_vec++;
      if (perf_ops !== 32'd10 || perf_stall !== 32'd4) begin
         n_err++;
         $display("FAIL perf: got ops=%0d stall=%0d, want ops=10 stall=4", perf_ops, perf_stall);
      end
      drain();
   endtask
`endif

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_sub    = '0;
      req_sign   = '0;
      resp_ready = 1'b0;
      m_ptr      = 0;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_backpressure();
      test_signed_ovf();
      test_unsigned_borrow();
      test_random();
`ifdef ADDER_ARB_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
